// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the two-master memory bus arbiter.
// Holds the FSM encoding, bus payload struct and the per-master request slicer.
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned N_MST  = 2;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    // Extract one master's request fields from the concatenated {m1, m0} buses.
    function automatic mem_req_t master_req(
        input logic [N_MST*ADDR_W-1:0] addr,
        input logic [N_MST*DATA_W-1:0] wdata,
        input logic [N_MST*STRB_W-1:0] wstrb,
        input logic                    idx
    );
        mem_req_t r;
        if (idx) begin
            r.addr  = addr[N_MST*ADDR_W-1 -: ADDR_W];
            r.wdata = wdata[N_MST*DATA_W-1 -: DATA_W];
            r.wstrb = wstrb[N_MST*STRB_W-1 -: STRB_W];
        end else begin
            r.addr  = addr[ADDR_W-1:0];
            r.wdata = wdata[DATA_W-1:0];
            r.wstrb = wstrb[STRB_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone request always wins, a tie goes to the
// master selected by prio (0 = master0, 1 = master1). Purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one valid/ready memory port between two masters: round-robin, one
// access in flight, grant held to completion, watchdog completes hung accesses.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MST-1:0]        m_valid,
    output logic [N_MST-1:0]        m_ready,
    input  logic [N_MST*ADDR_W-1:0] m_addr,
    input  logic [N_MST*DATA_W-1:0] m_wdata,
    input  logic [N_MST*STRB_W-1:0] m_wstrb,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    output logic [STRB_W-1:0]       s_wstrb,
    input  logic [DATA_W-1:0]       s_rdata,
    output logic [N_MST-1:0]        grant,
    output logic                    timeout_err
);

    localparam int unsigned       WDOG_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [N_MST-1:0]  grant_q, grant_d;
    logic              prio_q, prio_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    logic [N_MST-1:0]  arb_gnt;
    mem_req_t          sel_req;
    logic              busy;
    logic              owner_valid;
    logic              xfer_ok;
    logic              xfer_to;
    logic              xfer_abort;
    logic              xfer_end;

    rr_arb2 u_rr_arb2 (
        .req  (m_valid),
        .prio (prio_q),
        .gnt  (arb_gnt)
    );

    assign sel_req = master_req(m_addr, m_wdata, m_wstrb, grant_q[1]);

    // Ways a BUSY access ends; s_ready outranks the watchdog, a dropped request aborts silently.
    assign busy        = (state_q == ST_BUSY);
    assign owner_valid = |(m_valid & grant_q);
    assign xfer_ok     = busy && owner_valid && s_ready;
    assign xfer_to     = busy && owner_valid && !s_ready && (wdog_q == WDOG_LAST);
    assign xfer_abort  = busy && !owner_valid;
    assign xfer_end    = xfer_ok || xfer_to || xfer_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            prio_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next-state: arbitrate in IDLE, count and retire in BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        wdog_d  = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_valid) begin
                    state_d = ST_BUSY;
                    grant_d = arb_gnt;
                    wdog_d  = '0;
                end
            end
            ST_BUSY: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (xfer_end) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    wdog_d  = '0;
                    prio_d  = ~grant_q[1];
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                wdog_d  = '0;
            end
        endcase
    end

    // Slave-side mux and master-side completion, all zero outside an active access.
    always_comb begin
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m_ready     = '0;
        m_rdata     = '0;
        timeout_err = 1'b0;
        if (busy) begin
            s_valid = 1'b1;
            s_addr  = sel_req.addr;
            s_wdata = sel_req.wdata;
            s_wstrb = sel_req.wstrb;
            if (xfer_ok) begin
                m_ready = grant_q;
                m_rdata = s_rdata;
            end else if (xfer_to) begin
                m_ready     = grant_q;
                m_rdata     = ERR_RDATA;
                timeout_err = 1'b1;
            end
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two queued masters, a wait-state memory
// model, and hand-computed expectations for arbitration, timeout and reset cases.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_valid = '0;
    logic [1:0]  m_ready;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_wstrb = '0;
    logic [31:0] m_rdata;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = '0;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_req_t    q0[$];
    mem_req_t    q1[$];
    mem_req_t    mem_log[$];
    logic [32:0] done_log[$];
    logic [1:0]  rdy_seen = '0;

    int unsigned mem_wait   = 0;
    logic        mem_silent = 1'b0;
    logic [31:0] mem_rdata  = '0;
    int unsigned wcnt       = 0;

    mem_bus_arbiter #(.TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_rdata     (m_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic mem_req_t mk_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_req_t r;
        r.addr  = a;
        r.wdata = d;
        r.wstrb = s;
        return r;
    endfunction

    // Masters: present the head of their queue, pop it after a seen m_ready.
    always @(posedge clk) begin
        #1;
        if (m_valid[0] && rdy_seen[0] && q0.size() > 0) void'(q0.pop_front());
        if (m_valid[1] && rdy_seen[1] && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            m_valid[0] = 1'b1; m_addr[31:0] = q0[0].addr; m_wdata[31:0] = q0[0].wdata; m_wstrb[3:0] = q0[0].wstrb;
        end else begin
            m_valid[0] = 1'b0; m_addr[31:0] = '0; m_wdata[31:0] = '0; m_wstrb[3:0] = '0;
        end
        if (q1.size() > 0) begin
            m_valid[1] = 1'b1; m_addr[63:32] = q1[0].addr; m_wdata[63:32] = q1[0].wdata; m_wstrb[7:4] = q1[0].wstrb;
        end else begin
            m_valid[1] = 1'b0; m_addr[63:32] = '0; m_wdata[63:32] = '0; m_wstrb[7:4] = '0;
        end
    end

    // Memory: answers after mem_wait busy cycles unless silenced; logs each accepted access.
    always @(posedge clk) begin
        #2;
        if (s_valid) begin
            if (!mem_silent && wcnt == mem_wait) begin
                s_ready = 1'b1;
                s_rdata = mem_rdata;
                mem_log.push_back(mk_req(s_addr, s_wdata, s_wstrb));
                wcnt = 0;
            end else begin
                s_ready = 1'b0;
                s_rdata = '0;
                wcnt++;
            end
        end else begin
            s_ready = 1'b0;
            s_rdata = '0;
            wcnt = 0;
        end
    end

    // Completion monitor: every m_ready must belong to the current grant.
    always @(negedge clk) begin
        rdy_seen = m_ready;
        if (m_ready != 2'b00) begin
            done_log.push_back({m_ready[1], m_rdata});
            check_eq("ready_owner", 64'(m_ready), 64'(grant));
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && m_valid == 2'b00 && grant == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_quiet"}, 64'(ok), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int db, mb;
        logic [31:0] exp_a [4];
        logic        exp_m [4];

        // Reset state and single zero-wait read by m0
        reset_dut();
        check_eq("rst_grant", 64'(grant), 64'(0));
        check_eq("rst_s_valid", 64'(s_valid), 64'(0));
        check_eq("rst_m_ready", 64'(m_ready), 64'(0));
        check_eq("rst_timeout_err", 64'(timeout_err), 64'(0));
        check_eq("rst_m_rdata", 64'(m_rdata), 64'(0));
        check_eq("rst_s_addr", 64'(s_addr), 64'(0));
        mem_wait = 0; mem_rdata = 32'h1234_5678;
        q0.push_back(mk_req(32'h10, 32'h0, 4'h0));
        @(negedge clk);
        check_eq("t1_idle_s_valid", 64'(s_valid), 64'(0));
        @(negedge clk);
        check_eq("t1_s_valid", 64'(s_valid), 64'(1));
        check_eq("t1_grant", 64'(grant), 64'(2'b01));
        check_eq("t1_s_addr", 64'(s_addr), 64'(32'h10));
        check_eq("t1_s_wstrb", 64'(s_wstrb), 64'(0));
        check_eq("t1_m_ready", 64'(m_ready), 64'(2'b01));
        check_eq("t1_m_rdata", 64'(m_rdata), 64'(32'h1234_5678));
        check_eq("t1_timeout_err", 64'(timeout_err), 64'(0));
        @(negedge clk);
        check_eq("t1_grant_after", 64'(grant), 64'(0));
        check_eq("t1_s_valid_after", 64'(s_valid), 64'(0));
        check_eq("t1_m_ready_after", 64'(m_ready), 64'(0));
        check_eq("t1_m_rdata_after", 64'(m_rdata), 64'(0));

        // Both masters, two reads each, from reset: strict alternation m0,m1,m0,m1
        reset_dut();
        db = done_log.size(); mb = mem_log.size();
        mem_wait = 1; mem_rdata = 32'h2222_0000;
        q0.push_back(mk_req(32'h200, 32'h0, 4'h0));
        q0.push_back(mk_req(32'h208, 32'h0, 4'h0));
        q1.push_back(mk_req(32'h300, 32'h0, 4'h0));
        q1.push_back(mk_req(32'h308, 32'h0, 4'h0));
        wait_quiet("t2");
        exp_a[0] = 32'h200; exp_a[1] = 32'h300; exp_a[2] = 32'h208; exp_a[3] = 32'h308;
        exp_m[0] = 1'b0;    exp_m[1] = 1'b1;    exp_m[2] = 1'b0;    exp_m[3] = 1'b1;
        check_eq("t2_done_count", 64'(done_log.size() - db), 64'(4));
        check_eq("t2_mem_count", 64'(mem_log.size() - mb), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (db + i < done_log.size()) begin
                check_eq($sformatf("t2_owner%0d", i), 64'(done_log[db + i][32]), 64'(exp_m[i]));
                check_eq($sformatf("t2_rdata%0d", i), 64'(done_log[db + i][31:0]), 64'(32'h2222_0000));
            end
            if (mb + i < mem_log.size())
                check_eq($sformatf("t2_addr%0d", i), 64'(mem_log[mb + i].addr), 64'(exp_a[i]));
        end

        // m1 partial write passes through untouched, exactly once
        db = done_log.size(); mb = mem_log.size();
        mem_wait = 0; mem_rdata = 32'h0;
        q1.push_back(mk_req(32'h100, 32'hCAFE_BABE, 4'b0011));
        wait_quiet("t3");
        check_eq("t3_mem_count", 64'(mem_log.size() - mb), 64'(1));
        check_eq("t3_done_count", 64'(done_log.size() - db), 64'(1));
        if (mem_log.size() > mb) begin
            check_eq("t3_addr", 64'(mem_log[mb].addr), 64'(32'h100));
            check_eq("t3_wdata", 64'(mem_log[mb].wdata), 64'(32'hCAFE_BABE));
            check_eq("t3_wstrb", 64'(mem_log[mb].wstrb), 64'(4'b0011));
        end
        if (done_log.size() > db)
            check_eq("t3_owner", 64'(done_log[db][32]), 64'(1));

        // Watchdog: silent memory, m0 forced complete in BUSY cycle 8, then pending m1 served
        mem_silent = 1'b1;
        q0.push_back(mk_req(32'h40, 32'h0, 4'h0));
        q1.push_back(mk_req(32'h44, 32'h0, 4'h0));
        @(negedge clk);
        check_eq("t4_idle_grant", 64'(grant), 64'(0));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("t4_grant_m0", 64'(grant), 64'(2'b01));
            if (k == 7) begin
                check_eq("t4_c7_m_ready", 64'(m_ready), 64'(0));
                check_eq("t4_c7_timeout_err", 64'(timeout_err), 64'(0));
            end
        end
        check_eq("t4_c8_m_ready", 64'(m_ready), 64'(2'b01));
        check_eq("t4_c8_timeout_err", 64'(timeout_err), 64'(1));
        check_eq("t4_c8_m_rdata", 64'(m_rdata), 64'(32'hDEAD_BEEF));
        mem_silent = 1'b0; mem_wait = 0; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        check_eq("t4_gap_grant", 64'(grant), 64'(0));
        check_eq("t4_gap_timeout_err", 64'(timeout_err), 64'(0));
        @(negedge clk);
        check_eq("t4_m1_grant", 64'(grant), 64'(2'b10));
        check_eq("t4_m1_s_addr", 64'(s_addr), 64'(32'h44));
        check_eq("t4_m1_m_ready", 64'(m_ready), 64'(2'b10));
        check_eq("t4_m1_m_rdata", 64'(m_rdata), 64'(32'h5555_AAAA));
        check_eq("t4_m1_timeout_err", 64'(timeout_err), 64'(0));
        wait_quiet("t4");

        // s_ready on the exact watchdog cycle: real data, no error pulse
        mem_wait = 7; mem_rdata = 32'h7777_0008;
        q0.push_back(mk_req(32'h80, 32'h0, 4'h0));
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) check_eq("t5_c7_m_ready", 64'(m_ready), 64'(0));
        end
        check_eq("t5_c8_m_ready", 64'(m_ready), 64'(2'b01));
        check_eq("t5_c8_m_rdata", 64'(m_rdata), 64'(32'h7777_0008));
        check_eq("t5_c8_timeout_err", 64'(timeout_err), 64'(0));
        wait_quiet("t5");

        // Granted master withdraws mid-access: abort without m_ready
        db = done_log.size(); mb = mem_log.size();
        mem_wait = 5;
        q0.push_back(mk_req(32'hC0, 32'h0, 4'h0));
        repeat (3) @(negedge clk);
        check_eq("ab_c2_s_valid", 64'(s_valid), 64'(1));
        q0.delete();
        @(negedge clk);
        check_eq("ab_c3_s_valid", 64'(s_valid), 64'(1));
        check_eq("ab_c3_m_ready", 64'(m_ready), 64'(0));
        @(negedge clk);
        check_eq("ab_s_valid", 64'(s_valid), 64'(0));
        check_eq("ab_grant", 64'(grant), 64'(0));
        check_eq("ab_no_done", 64'(done_log.size()), 64'(db));
        check_eq("ab_no_mem", 64'(mem_log.size()), 64'(mb));

        // Reset pulsed while BUSY with 5 wait states, then a fresh m0 read
        wait_quiet("t6_pre");
        db = done_log.size(); mb = mem_log.size();
        mem_wait = 5;
        q0.push_back(mk_req(32'hE0, 32'h0, 4'h0));
        repeat (4) @(negedge clk);
        check_eq("t6_busy_s_valid", 64'(s_valid), 64'(1));
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        check_eq("t6_s_valid", 64'(s_valid), 64'(0));
        check_eq("t6_grant", 64'(grant), 64'(0));
        check_eq("t6_m_ready", 64'(m_ready), 64'(0));
        check_eq("t6_timeout_err", 64'(timeout_err), 64'(0));
        check_eq("t6_s_addr", 64'(s_addr), 64'(0));
        rst = 1'b0;
        check_eq("t6_no_done", 64'(done_log.size()), 64'(db));
        check_eq("t6_no_mem", 64'(mem_log.size()), 64'(mb));
        mem_wait = 0; mem_rdata = 32'h600D_0001;
        q0.push_back(mk_req(32'hE4, 32'h0, 4'h0));
        wait_quiet("t6");
        check_eq("t6_fresh_done", 64'(done_log.size() - db), 64'(1));
        if (done_log.size() > db)
            check_eq("t6_fresh_data", 64'(done_log[db]), 64'({1'b0, 32'h600D_0001}));
        if (mem_log.size() > mb)
            check_eq("t6_fresh_addr", 64'(mem_log[mb].addr), 64'(32'hE4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
